// File: rtl/guvm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : guvm_mem_pkg
// Purpose  : Shared types and constants for the data-memory responder.
//            resp_t      - one response beat (read data + error flag)
//            gnt_state_e - grant FSM state encoding
//            BAD_RDATA   - read data returned for out-of-range reads
// Revision : 1.0 - initial release
// ============================================================================
package guvm_mem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } gnt_state_e;

    localparam logic [31:0] BAD_RDATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/guvm_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : guvm_resp_pipe
// Purpose  : DEPTH-stage shift register carrying {valid, resp_t} from the
//            handshake cycle to the response cycle. Synchronous flush on
//            rst_i discards every in-flight response.
// Ports    : clk_i, rst_i          - clock, sync active-high reset
//            in_valid_i/in_resp_i  - response entering the pipe
//            out_valid_o/out_resp_o- response leaving after DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
module guvm_resp_pipe
    import guvm_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  in_valid_i,
    input  resp_t in_resp_i,
    output logic  out_valid_o,
    output resp_t out_resp_o
);

    logic [DEPTH-1:0] valid_q;
    resp_t            resp_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            resp_q[0]  <= in_resp_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_resp_o  = resp_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/guvm_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : guvm_data_mem_responder
// Purpose  : Data-memory slave for an OBI-style req/gnt/rvalid port. Grants
//            after GNT_DELAY held cycles, caps outstanding transactions,
//            returns in-order responses RVALID_LATENCY cycles after the
//            handshake and exports every applied write.
// Ports    : clk_i, rst_i            - clock, sync active-high reset
//            data_req_i/we/be/addr/wdata - core request
//            data_gnt_o              - grant (handshake = req & gnt)
//            data_rvalid_o/rdata_o   - response beat (rdata 0 for writes)
//            data_err_o              - out-of-range flag, only when the
//                                      GUVM_MEM_ERR_EN macro is defined
//            wr_valid_o/addr_o/data_o- write export, one cycle after accept
// Revision : 1.0 - initial release
// ============================================================================
module guvm_data_mem_responder
    import guvm_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MEM_DEPTH       = 1024,
    parameter int GNT_DELAY       = 0,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
`ifdef GUVM_MEM_ERR_EN
    output logic                  data_err_o,
`endif
    output logic                  wr_valid_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o
);

    localparam int c_idx_w = ADDR_WIDTH - 2;
    localparam int c_mem_aw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int c_cnt_w = (GNT_DELAY > 1) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);
    // WAIT hands over to GRANT once req has been held GNT_DELAY-1 cycles,
    // so gnt appears in cycle GNT_DELAY+1 of a continuously held request.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(GNT_DELAY - 1);
    localparam logic [c_out_w-1:0] c_out_max  = c_out_w'(MAX_OUTSTANDING);

    gnt_state_e          state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [c_out_w-1:0]  outst_q, outst_d;

    logic [31:0]         mem_q [MEM_DEPTH];

    logic                wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]         wr_data_q;

    logic                w_hs;
    logic                w_cap_ok;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_mem_aw-1:0] w_mem_idx;
    logic                w_in_range;
    logic [31:0]         w_rd_word;
    logic [31:0]         w_merged;
    resp_t               w_resp;
    logic                w_pipe_valid;
    resp_t               w_pipe_resp;
    logic [1:0]          w_unused_addr;

    assign w_unused_addr = data_addr_i[1:0];

    assign w_hs       = data_req_i & data_gnt_o;
    // A response retiring this cycle frees a slot for a same-cycle accept.
    assign w_cap_ok   = (outst_q < c_out_max) | data_rvalid_o;

    assign w_idx      = data_addr_i[ADDR_WIDTH-1:2];
    assign w_mem_idx  = w_idx[c_mem_aw-1:0];
    assign w_in_range = (w_idx < c_idx_w'(MEM_DEPTH));
    assign w_rd_word  = mem_q[w_mem_idx];

    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
                w_merged[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
    end

    // ---------------- grant FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- grant FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (data_req_i && (GNT_DELAY > 0)) begin
                    if (GNT_DELAY == 1) begin
                        state_d = GRANT;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = c_cnt_w'(1);
                    end
                end
            end
            WAIT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_cnt_last) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT: begin
                if (!data_req_i || w_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- grant FSM: outputs ----------------
    // Grant is masked while rst_i is high so nothing is accepted in reset.
    always_comb begin
        data_gnt_o = 1'b0;
        unique case (state_q)
            IDLE:    data_gnt_o = data_req_i && (GNT_DELAY == 0) && w_cap_ok && !rst_i;
            GRANT:   data_gnt_o = data_req_i && w_cap_ok && !rst_i;
            default: data_gnt_o = 1'b0;
        endcase
    end

    // ---------------- outstanding counter ----------------
    always_comb begin
        outst_d = outst_q;
        if (w_hs && !data_rvalid_o) begin
            outst_d = outst_q + 1'b1;
        end else if (!w_hs && data_rvalid_o) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    // ---------------- backing store (never reset) ----------------
    always_ff @(posedge clk_i) begin
        if (w_hs && data_we_i && w_in_range) begin
            mem_q[w_mem_idx] <= w_merged;
        end
    end

    // ---------------- write export ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= w_hs & data_we_i & w_in_range;
            wr_addr_q  <= {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
            wr_data_q  <= w_merged;
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

    // ---------------- response path ----------------
    // Idle slots carry an all-zero beat so rdata reads 0 when rvalid is low.
    always_comb begin
        w_resp = '0;
        if (w_hs) begin
            w_resp.err = ~w_in_range;
            if (!data_we_i) begin
                w_resp.rdata = w_in_range ? w_rd_word : BAD_RDATA;
            end
        end
    end

    guvm_resp_pipe #(
        .DEPTH (RVALID_LATENCY)
    ) u_resp_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (w_hs),
        .in_resp_i   (w_resp),
        .out_valid_o (w_pipe_valid),
        .out_resp_o  (w_pipe_resp)
    );

    assign data_rvalid_o = w_pipe_valid;
    assign data_rdata_o  = w_pipe_resp.rdata;

`ifdef GUVM_MEM_ERR_EN
    assign data_err_o = w_pipe_resp.err;
`else
    logic w_unused_err;
    assign w_unused_err = w_pipe_resp.err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_guvm_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_guvm_data_mem_responder
// Purpose  : Directed self-checking bench. Three responder instances:
//            u_a defaults, u_b GNT_DELAY=3 / RVALID_LATENCY=2,
//            u_c RVALID_LATENCY=3 / MAX_OUTSTANDING=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_guvm_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A (defaults) ----------------
    logic        a_rst, a_req, a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata;
    logic        a_gnt, a_rvalid, a_wr_valid;
    logic [31:0] a_rdata, a_wr_addr, a_wr_data;
`ifdef GUVM_MEM_ERR_EN
    logic        a_err;
`endif

    guvm_data_mem_responder u_a (
        .clk_i (clk), .rst_i (a_rst),
        .data_req_i (a_req), .data_we_i (a_we), .data_be_i (a_be),
        .data_addr_i (a_addr), .data_wdata_i (a_wdata),
        .data_gnt_o (a_gnt), .data_rvalid_o (a_rvalid), .data_rdata_o (a_rdata),
`ifdef GUVM_MEM_ERR_EN
        .data_err_o (a_err),
`endif
        .wr_valid_o (a_wr_valid), .wr_addr_o (a_wr_addr), .wr_data_o (a_wr_data)
    );

    // ---------------- instance B (grant delay 3, latency 2) ----------------
    logic        b_rst, b_req, b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata;
    logic        b_gnt, b_rvalid, b_wr_valid;
    logic [31:0] b_rdata, b_wr_addr, b_wr_data;
`ifdef GUVM_MEM_ERR_EN
    logic        b_err;
`endif

    guvm_data_mem_responder #(.GNT_DELAY (3), .RVALID_LATENCY (2)) u_b (
        .clk_i (clk), .rst_i (b_rst),
        .data_req_i (b_req), .data_we_i (b_we), .data_be_i (b_be),
        .data_addr_i (b_addr), .data_wdata_i (b_wdata),
        .data_gnt_o (b_gnt), .data_rvalid_o (b_rvalid), .data_rdata_o (b_rdata),
`ifdef GUVM_MEM_ERR_EN
        .data_err_o (b_err),
`endif
        .wr_valid_o (b_wr_valid), .wr_addr_o (b_wr_addr), .wr_data_o (b_wr_data)
    );

    // ---------------- instance C (latency 3, cap 2) ----------------
    logic        c_rst, c_req, c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr, c_wdata;
    logic        c_gnt, c_rvalid, c_wr_valid;
    logic [31:0] c_rdata, c_wr_addr, c_wr_data;
`ifdef GUVM_MEM_ERR_EN
    logic        c_err;
`endif

    guvm_data_mem_responder #(.RVALID_LATENCY (3), .MAX_OUTSTANDING (2)) u_c (
        .clk_i (clk), .rst_i (c_rst),
        .data_req_i (c_req), .data_we_i (c_we), .data_be_i (c_be),
        .data_addr_i (c_addr), .data_wdata_i (c_wdata),
        .data_gnt_o (c_gnt), .data_rvalid_o (c_rvalid), .data_rdata_o (c_rdata),
`ifdef GUVM_MEM_ERR_EN
        .data_err_o (c_err),
`endif
        .wr_valid_o (c_wr_valid), .wr_addr_o (c_wr_addr), .wr_data_o (c_wr_data)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
    endtask

    // Each cycle: drive, wait #3 so outputs settle mid-cycle, check, tick.
    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
        c_req = 1'b0; c_we = 1'b0; c_be = 4'h0; c_addr = 32'h0; c_wdata = 32'h0;
        tick(); tick();

        // ---- reset state ----
        #3;
        check("rst_gnt",      {31'd0, a_gnt},      32'd0);
        check("rst_rvalid",   {31'd0, a_rvalid},   32'd0);
        check("rst_rdata",    a_rdata,             32'd0);
        check("rst_wr_valid", {31'd0, a_wr_valid}, 32'd0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        tick();

        // ---- A: full write then read back ----
        a_drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hA5A5_1234); #3;
        check("a_w1_gnt", {31'd0, a_gnt}, 32'd1);
        tick();
        a_drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0); #3;
        check("a_r1_gnt",      {31'd0, a_gnt},      32'd1);
        check("a_w1_rvalid",   {31'd0, a_rvalid},   32'd1);
        check("a_w1_rdata0",   a_rdata,             32'd0);
        check("a_w1_wr_valid", {31'd0, a_wr_valid}, 32'd1);
        check("a_w1_wr_addr",  a_wr_addr,           32'h10);
        check("a_w1_wr_data",  a_wr_data,           32'hA5A5_1234);
        tick();
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #3;
        check("a_r1_rvalid",   {31'd0, a_rvalid},   32'd1);
        check("a_r1_rdata",    a_rdata,             32'hA5A5_1234);
        check("a_r1_wr_quiet", {31'd0, a_wr_valid}, 32'd0);
        tick();
        #3;
        check("a_idle_rvalid", {31'd0, a_rvalid}, 32'd0);
        tick();

        // ---- A: partial byte write ----
        a_drive(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_EE00); tick();
        a_drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0); #3;
        check("a_be2_wr_data", a_wr_data, 32'hA5A5_EE34);
        tick();
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #3;
        check("a_be2_rdata", a_rdata, 32'hA5A5_EE34);
        tick();

        // ---- A: be=0 write pulses wr_valid but leaves data ----
        a_drive(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF); tick();
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #3;
        check("a_be0_wr_valid", {31'd0, a_wr_valid}, 32'd1);
        check("a_be0_wr_data",  a_wr_data,           32'hA5A5_EE34);
        tick();

        // ---- A: unaligned address, top byte only ----
        a_drive(1'b1, 1'b1, 4'b1000, 32'h12, 32'h7700_0000); tick();
        a_drive(1'b1, 1'b0, 4'hF, 32'h13, 32'h0); #3;
        check("a_ua_wr_addr", a_wr_addr, 32'h10);
        check("a_ua_wr_data", a_wr_data, 32'h77A5_EE34);
        tick();
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #3;
        check("a_ua_rdata", a_rdata, 32'h77A5_EE34);
        tick();

        // ---- A: last in-range word ----
        a_drive(1'b1, 1'b1, 4'hF, 32'hFFC, 32'h0BAD_F00D); tick();
        a_drive(1'b1, 1'b0, 4'hF, 32'hFFC, 32'h0); #3;
        check("a_top_wr_valid", {31'd0, a_wr_valid}, 32'd1);
        tick();
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #3;
        check("a_top_rdata", a_rdata, 32'h0BAD_F00D);
`ifdef GUVM_MEM_ERR_EN
        check("a_top_err", {31'd0, a_err}, 32'd0);
`endif
        tick();

        // ---- A: out-of-range read and write (index 1024) ----
        a_drive(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0); #3;
        check("a_oor_gnt", {31'd0, a_gnt}, 32'd1);
        tick();
        a_drive(1'b1, 1'b1, 4'hF, 32'h1000, 32'h1111_1111); #3;
        check("a_oor_rd_rvalid", {31'd0, a_rvalid}, 32'd1);
        check("a_oor_rd_rdata",  a_rdata,           32'hDEAD_BEEF);
`ifdef GUVM_MEM_ERR_EN
        check("a_oor_rd_err", {31'd0, a_err}, 32'd1);
`endif
        tick();
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #3;
        check("a_oor_wr_valid", {31'd0, a_wr_valid}, 32'd0);
        check("a_oor_wr_rvalid", {31'd0, a_rvalid}, 32'd1);
        check("a_oor_wr_rdata", a_rdata, 32'd0);
`ifdef GUVM_MEM_ERR_EN
        check("a_oor_wr_err", {31'd0, a_err}, 32'd1);
`endif
        tick();

        // ---- B: GNT_DELAY=3, gnt in 4th held cycle ----
        b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h20; b_wdata = 32'h1122_3344;
        #3; check("b_d_c1_gnt", {31'd0, b_gnt}, 32'd0); tick();
        #3; check("b_d_c2_gnt", {31'd0, b_gnt}, 32'd0); tick();
        #3; check("b_d_c3_gnt", {31'd0, b_gnt}, 32'd0); tick();
        #3; check("b_d_c4_gnt", {31'd0, b_gnt}, 32'd1); tick();
        b_req = 1'b0; #3;
        check("b_d_after_gnt", {31'd0, b_gnt},      32'd0);
        check("b_d_wr_valid",  {31'd0, b_wr_valid}, 32'd1);
        check("b_d_wr_data",   b_wr_data,           32'h1122_3344);
        check("b_d_rvalid_l1", {31'd0, b_rvalid},   32'd0);
        tick();
        #3; check("b_d_rvalid_l2", {31'd0, b_rvalid}, 32'd1); tick();

        // ---- B: req dropped after 2 cycles, then restart from IDLE ----
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
        tick(); tick();
        b_req = 1'b0; #3; check("b_drop_gnt", {31'd0, b_gnt}, 32'd0); tick();
        b_req = 1'b1;
        #3; check("b_re_c1_gnt", {31'd0, b_gnt}, 32'd0); tick();
        tick();
        #3; check("b_re_c3_gnt", {31'd0, b_gnt}, 32'd0); tick();
        #3; check("b_re_c4_gnt", {31'd0, b_gnt}, 32'd1); tick();

        // ---- B: reset one cycle after read handshake flushes response ----
        b_req = 1'b0; b_rst = 1'b1; #3;
        check("b_rst_rvalid_c1", {31'd0, b_rvalid}, 32'd0);
        tick();
        b_rst = 1'b0; #3;
        check("b_rst_rvalid", {31'd0, b_rvalid},   32'd0);
        check("b_rst_rdata",  b_rdata,             32'd0);
        check("b_rst_gnt",    {31'd0, b_gnt},      32'd0);
        check("b_rst_wr",     {31'd0, b_wr_valid}, 32'd0);
        tick();
        #3; check("b_rst_rvalid_late", {31'd0, b_rvalid}, 32'd0); tick();

        // ---- B: memory survives reset ----
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
        tick(); tick(); tick();
        #3; check("b_post_gnt", {31'd0, b_gnt}, 32'd1); tick();
        b_req = 1'b0; tick();
        #3;
        check("b_post_rvalid", {31'd0, b_rvalid}, 32'd1);
        check("b_post_rdata",  b_rdata,           32'h1122_3344);
        tick();

        // ---- C: latency 3, cap 2, req held ----
        c_req = 1'b1; c_we = 1'b1; c_be = 4'hF; c_addr = 32'h0; c_wdata = 32'hCAFE_0000;
        #3; check("c_c1_gnt", {31'd0, c_gnt}, 32'd1); tick();
        #3; check("c_c2_gnt", {31'd0, c_gnt}, 32'd1); tick();
        #3; check("c_c3_gnt", {31'd0, c_gnt}, 32'd0);
            check("c_c3_rvalid", {31'd0, c_rvalid}, 32'd0); tick();
        #3; check("c_c4_rvalid", {31'd0, c_rvalid}, 32'd1);
            check("c_c4_gnt", {31'd0, c_gnt}, 32'd1); tick();
        #3; check("c_c5_rvalid", {31'd0, c_rvalid}, 32'd1);
            check("c_c5_gnt", {31'd0, c_gnt}, 32'd1); tick();
        #3; check("c_c6_rvalid", {31'd0, c_rvalid}, 32'd0);
            check("c_c6_gnt", {31'd0, c_gnt}, 32'd0); tick();
        #3; check("c_c7_rvalid", {31'd0, c_rvalid}, 32'd1);
            check("c_c7_gnt", {31'd0, c_gnt}, 32'd1); tick();
        c_req = 1'b0;
        #3; check("c_c8_rvalid", {31'd0, c_rvalid}, 32'd1);
            check("c_c8_rdata", c_rdata, 32'd0); tick();
        #3; check("c_c9_rvalid", {31'd0, c_rvalid}, 32'd0); tick();
        #3; check("c_c10_rvalid", {31'd0, c_rvalid}, 32'd1); tick();
        #3; check("c_c11_rvalid", {31'd0, c_rvalid}, 32'd0); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
